// File: rtl/sobel_pixel_streamer.sv
// sobel_pixel_streamer: reads one grayscale frame in raster order from a
// single-port block RAM and presents it as a valid/ready pixel stream with
// sof/eol/eof markers and column/row positions for the Sobel edge stage.
// The RAM read latency is hidden behind a small credit-controlled FIFO.
//
// Build option: define SOBEL_STREAMER_LOOP_EN to stream frames back-to-back
// (video mode). Without it the block returns to IDLE after each frame.
module sobel_pixel_streamer #(
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic [CW-1:0]     pix_col,
  output logic [RW-1:0]     pix_row
);

  // FIFO depth covers every read that can be in flight plus one pixel
  // stalled at the head, which is what keeps the stream bubble-free.
  localparam int D    = RD_LAT + 2;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(D);
  localparam int NW   = $clog2(D + 1);
  localparam int SW   = NW + 1;

  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(BASE_ADDR + NPIX - 1);
  localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [PW-1:0]     PTR_LAST   = PW'(D - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [RD_LAT-1:0]   rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]   fifo_q [D];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;

  logic                issue;
  logic                push;
  logic                pop;
  logic                head_eof;
  logic                fifo_nempty;
  logic [NW-1:0]       in_flight;

  // Number of reads still travelling through the RAM pipeline.
  function automatic logic [NW-1:0] ones(input logic [RD_LAT-1:0] v);
    logic [NW-1:0] n;
    n = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      n = n + NW'(v[k]);
    end
    return n;
  endfunction

  // FIFO pointers wrap at D, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit check, handshake and head-of-FIFO decode.
  always_comb begin
    in_flight   = ones(rd_vld_q);
    issue       = (state_q == ST_STREAM) &&
                  ((SW'(cnt_q) + SW'(in_flight)) < SW'(D));
    push        = rd_vld_q[RD_LAT-1];
    fifo_nempty = (cnt_q != '0);
    pop         = fifo_nempty && pix_ready;
    head_eof    = (col_q == COL_LAST) && (row_q == ROW_LAST);
  end

  // Next-state for address, in-flight tracker, FIFO bookkeeping and position.
  always_comb begin
    addr_d = addr_q;
    if (issue) begin
      addr_d = (addr_q == ADDR_LAST) ? ADDR_FIRST : addr_q + ADDR_W'(1);
    end

    // Shift in this cycle's read; the oldest bit marks data arriving now.
    rd_vld_d = RD_LAT'({rd_vld_q, issue});

    wr_ptr_d = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + NW'(1);
      2'b01:   cnt_d = cnt_q - NW'(1);
      default: cnt_d = cnt_q;
    endcase

    col_d = col_q;
    row_d = row_q;
    if (pop) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Control registers; reset also discards anything still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= ADDR_FIRST;
      rd_vld_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      rd_vld_q <= rd_vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  // FIFO storage: captures RAM data when the matching read completes.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_dout;
    end
  end

  // Frame sequencer with registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_STREAM;
            busy_q  <= 1'b1;
          end
        end
        ST_STREAM: begin
`ifdef SOBEL_STREAMER_LOOP_EN
          // The address wraps to BASE_ADDR on its own, so reads for the next
          // frame follow straight on and the frame boundary has no bubble.
          if (pop && head_eof) begin
            done_q <= 1'b1;
          end
`else
          if (issue && (addr_q == ADDR_LAST)) begin
            state_q <= ST_DRAIN;
          end
`endif
        end
        ST_DRAIN: begin
          if (pop && head_eof) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode; data and markers read as zero while the FIFO is empty.
  always_comb begin
    busy      = busy_q;
    done      = done_q;
    mem_en    = issue;
    mem_addr  = addr_q;
    pix_valid = fifo_nempty;
    pix_data  = fifo_nempty ? fifo_q[rd_ptr_q] : '0;
    pix_sof   = fifo_nempty && (col_q == '0) && (row_q == '0);
    pix_eol   = fifo_nempty && (col_q == COL_LAST);
    pix_eof   = fifo_nempty && head_eof;
    pix_col   = col_q;
    pix_row   = row_q;
  end

endmodule

// File: tb/tb_sobel_pixel_streamer.sv
// Bench for sobel_pixel_streamer on a 4x3 image with RAM[i] = i.
// Instance A uses RD_LAT=1, instance B uses RD_LAT=2. A reference model maps
// the k-th accepted pixel of a frame to its value, position and markers.
`timescale 1ns/1ps
module tb_sobel_pixel_streamer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: pixel k of the stream is RAM[k mod N] at raster position k mod N.
  task automatic chk_pix(input string tag, input int k, input logic [7:0] d,
                         input logic sof, input logic eol, input logic eof,
                         input logic [1:0] col, input logic [1:0] row);
    int p;
    p = k % N;
    chk({tag, "_data"}, d, p);
    chk({tag, "_sof"}, sof, (p == 0));
    chk({tag, "_eol"}, eol, (p % W == W - 1));
    chk({tag, "_eof"}, eof, (p == N - 1));
    chk({tag, "_col"}, col, p % W);
    chk({tag, "_row"}, row, p / W);
  endtask

  // ---------------- instance A (RD_LAT = 1) ----------------
  logic       a_start, a_busy, a_done, a_mem_en, a_valid, a_ready;
  logic [15:0] a_mem_addr;
  logic [7:0] a_mem_dout = '0;
  logic [7:0] a_data;
  logic       a_sof, a_eol, a_eof;
  logic [1:0] a_col, a_row;

  sobel_pixel_streamer #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .ADDR_W(16),
                         .BASE_ADDR(0), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_dout(a_mem_dout),
    .pix_valid(a_valid), .pix_ready(a_ready), .pix_data(a_data),
    .pix_sof(a_sof), .pix_eol(a_eol), .pix_eof(a_eof),
    .pix_col(a_col), .pix_row(a_row));

  always @(posedge clk) if (a_mem_en) a_mem_dout <= a_mem_addr[7:0];

  // ---------------- instance B (RD_LAT = 2) ----------------
  logic       b_start, b_busy, b_done, b_mem_en, b_valid, b_ready;
  logic [15:0] b_mem_addr;
  logic [7:0] b_rd1 = '0;
  logic [7:0] b_mem_dout = '0;
  logic [7:0] b_data;
  logic       b_sof, b_eol, b_eof;
  logic [1:0] b_col, b_row;

  sobel_pixel_streamer #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .ADDR_W(16),
                         .BASE_ADDR(0), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_dout(b_mem_dout),
    .pix_valid(b_valid), .pix_ready(b_ready), .pix_data(b_data),
    .pix_sof(b_sof), .pix_eol(b_eol), .pix_eof(b_eof),
    .pix_col(b_col), .pix_row(b_row));

  always @(posedge clk) begin
    if (b_mem_en) b_rd1 <= b_mem_addr[7:0];
    b_mem_dout <= b_rd1;
  end

  // ---------------- compare process, instance A ----------------
  int a_xfer = 0, a_issued = 0, a_ndone = 0, a_nsof = 0;
  int a_eof_cyc = -10, a_eof_data = -1, a_fv_cyc = -1, a_fv_data = -1;
  int a_first_xfer_cyc = -1, a_last_xfer_cyc = -1, a_busy_drop = 0;
  bit a_watch = 0;
  logic a_stall = 1'b0;
  logic [14:0] a_saved = '0;

  always @(negedge clk) begin
    if (rst) begin
      a_xfer = 0; a_issued = 0; a_stall = 1'b0;
    end else begin
      if (a_done) begin
        a_ndone++;
        chk("a_done_cycle", cyc, a_eof_cyc + 1);
`ifdef SOBEL_STREAMER_LOOP_EN
        chk("a_busy_at_done", a_busy, 1);
`else
        chk("a_busy_at_done", a_busy, 0);
`endif
      end
      if (a_mem_en) begin
        chk("a_mem_addr", a_mem_addr, a_issued % N);
        a_issued++;
      end
      chk("a_occupancy_le_3", (a_issued - a_xfer) <= 3, 1);
      if (a_stall) begin
        chk("a_hold_valid", a_valid, 1);
        chk("a_hold_fields", {a_data, a_sof, a_eol, a_eof, a_col, a_row}, a_saved);
      end
      if (a_valid && a_fv_cyc < 0) begin
        a_fv_cyc = cyc; a_fv_data = a_data;
      end
      if (a_valid && a_ready) begin
        chk_pix("a", a_xfer, a_data, a_sof, a_eol, a_eof, a_col, a_row);
        if (a_eof) begin
          a_eof_cyc = cyc; a_eof_data = a_data;
          chk("a_busy_at_eof", a_busy, 1);
        end
        if (a_sof) a_nsof++;
        if (a_first_xfer_cyc < 0) a_first_xfer_cyc = cyc;
        a_last_xfer_cyc = cyc;
        a_xfer++;
      end
      a_stall = a_valid && !a_ready;
      a_saved = {a_data, a_sof, a_eol, a_eof, a_col, a_row};
      if (a_watch && !a_busy) a_busy_drop++;
    end
  end

  // ---------------- compare process, instance B ----------------
  int b_xfer = 0, b_issued = 0, b_ndone = 0, b_fv_cyc = -1;
  logic b_stall = 1'b0;
  logic [14:0] b_saved = '0;

  always @(negedge clk) begin
    if (rst) begin
      b_xfer = 0; b_issued = 0; b_stall = 1'b0;
    end else begin
      if (b_done) b_ndone++;
      if (b_mem_en) begin
        chk("b_mem_addr", b_mem_addr, b_issued % N);
        b_issued++;
      end
      chk("b_occupancy_le_4", (b_issued - b_xfer) <= 4, 1);
      if (b_stall) begin
        chk("b_hold_valid", b_valid, 1);
        chk("b_hold_fields", {b_data, b_sof, b_eol, b_eof, b_col, b_row}, b_saved);
      end
      if (b_valid && b_fv_cyc < 0) b_fv_cyc = cyc;
      if (b_valid && b_ready) begin
        chk_pix("b", b_xfer, b_data, b_sof, b_eol, b_eof, b_col, b_row);
        b_xfer++;
      end
      b_stall = b_valid && !b_ready;
      b_saved = {b_data, b_sof, b_eol, b_eof, b_col, b_row};
    end
  end

`ifndef SOBEL_STREAMER_LOOP_EN
  // One full frame on A. mode 0: ready held high; mode 1: ready 1,0,0,1...
  // Latency is counted from the edge that launches start (start is driven
  // just after it and sampled on the next one).
  task automatic frame_a(input int mode, input bit poke);
    int x0, nd0, s, n, iss0;
    bit poked;
    x0 = a_xfer; nd0 = a_ndone; a_fv_cyc = -1; a_first_xfer_cyc = -1;
    poked = 0; n = 0;
    @(posedge clk); #1;
    a_start = 1'b1; a_ready = 1'b1; s = cyc;
    while (a_ndone == nd0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      a_start = 1'b0;
      if (poke && !poked && (a_xfer - x0) == 6) begin
        a_start = 1'b1; poked = 1;
      end
      a_ready = (mode == 0) || (n % 4 == 0) || (n % 4 == 3);
    end
    a_ready = 1'b1;
    chk("a_frame_bound", n < 300, 1);
    chk("a_frame_xfers", a_xfer - x0, 12);
    chk("a_first_valid_latency", a_fv_cyc - s, 3);
    chk("a_first_data", a_fv_data, 0);
    chk("a_eof_data", a_eof_data, 11);
    if (mode == 0) chk("a_no_bubble", a_last_xfer_cyc - a_first_xfer_cyc, 11);
    iss0 = a_issued;
    repeat (8) @(posedge clk);
    #1;
    chk("a_single_done", a_ndone - nd0, 1);
    chk("a_idle_busy", a_busy, 0);
    chk("a_idle_no_reads", a_issued - iss0, 0);
    chk("a_idle_no_xfers", a_xfer - x0, 12);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int n, x0, s;
    rst = 1'b1;
    a_start = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_ready = 1'b1;
    repeat (2) @(negedge clk);
    // Reset values.
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_mem_en", a_mem_en, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    chk("rst_sof", a_sof, 0);
    chk("rst_eol", a_eol, 0);
    chk("rst_eof", a_eof, 0);
    chk("rst_col", a_col, 0);
    chk("rst_row", a_row, 0);
    chk("rst_b_mem_en", b_mem_en, 0);
    chk("rst_b_valid", b_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifndef SOBEL_STREAMER_LOOP_EN
    // Plain frame, then the 1,0,0,1 ready pattern.
    frame_a(0, 0);
    frame_a(1, 0);

    // Reset after the fifth transfer; the following frame must start clean.
    x0 = a_xfer;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    n = 0;
    while ((a_xfer - x0) < 5 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("a_mid_bound", n < 100, 1);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("a_after_rst_busy", a_busy, 0);
    chk("a_after_rst_valid", a_valid, 0);
    chk("a_after_rst_col", a_col, 0);
    chk("a_after_rst_row", a_row, 0);
    frame_a(0, 0);

    // start pulsed mid-frame is ignored.
    frame_a(0, 1);

    // B: ready held low for 20 cycles; credits allow exactly D=4 reads.
    b_fv_cyc = -1;
    @(posedge clk); #1;
    b_ready = 1'b0; b_start = 1'b1; s = cyc;
    @(posedge clk); #1 b_start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("b_reads_while_stalled", b_issued, 4);
    chk("b_mem_en_stalled", b_mem_en, 0);
    chk("b_valid_stalled", b_valid, 1);
    chk("b_first_valid_latency", b_fv_cyc - s, 4);
    b_ready = 1'b1;
    n = 0;
    while (b_ndone == 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("b_frame_bound", n < 200, 1);
    chk("b_frame_xfers", b_xfer, 12);
    chk("b_busy_after", b_busy, 0);
`else
    // Back-to-back frames with ready held high.
    a_fv_cyc = -1; a_first_xfer_cyc = -1;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(posedge clk); #1 a_watch = 1;
    n = 0;
    while (a_xfer < 24 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("loop_bound", n < 200, 1);
    chk("loop_no_bubble", a_last_xfer_cyc - a_first_xfer_cyc, 23);
    chk("loop_sof_count", a_nsof, 2);
    chk("loop_first_data", a_fv_data, 0);
    @(negedge clk); #1;
    chk("loop_done_count", a_ndone, 2);
    chk("loop_busy_never_drops", a_busy_drop, 0);
    a_watch = 0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("loop_rst_busy", a_busy, 0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
